// File: rtl/reg_file_8x8.sv
// reg_file_8x8: 8-entry x 8-bit register file feeding the ALU operands.
//   - Two combinational read ports (OUT1 -> ALU DATA1, OUT2 -> ALU DATA2).
//   - One synchronous write port (ALU RESULT returns on IN).
//   - VALID_MASK flags every register written since the last reset.
//   - Asynchronous active-low RESET clears storage and valid mask at once.
// Optional build macro: REGFILE_BYPASS_EN
//   When defined, a read port whose address matches INADDRESS during an
//   active write shows IN (and valid=1) combinationally, before the edge.
//   When undefined, read ports show stored contents only.
module reg_file_8x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [DATA_WIDTH-1:0]      IN,
    input  logic [ADDR_WIDTH-1:0]      INADDRESS,
    input  logic                       WRITE,
    input  logic [ADDR_WIDTH-1:0]      OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0]      OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0]      OUT1,
    output logic [DATA_WIDTH-1:0]      OUT2,
    output logic                       OUT1_VALID,
    output logic                       OUT2_VALID,
    output logic [(2**ADDR_WIDTH)-1:0] VALID_MASK
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage and per-register written-since-reset flags.
    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_valid;

    // Qualified write strobe and its one-hot register select.
    logic                  w_wr_en;
    logic [DEPTH-1:0]      w_wr_sel;

    // Raw stored values seen by each read port before any bypass.
    logic [DATA_WIDTH-1:0] w_rd1_data;
    logic [DATA_WIDTH-1:0] w_rd2_data;
    logic                  w_rd1_vld;
    logic                  w_rd2_vld;

    // Qualify WRITE: an unknown or low strobe is treated as no write.
    // The if-form sends X down the else path in simulation.
    always_comb begin
        w_wr_en = 1'b0;
        if (WRITE) begin
            w_wr_en = 1'b1;
        end
    end

    // Decode the write address into a one-hot register select.
    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_en && (INADDRESS == ADDR_WIDTH'(i))) begin
                w_wr_sel[i] = 1'b1;
            end
        end
    end

    // Each register captures IN on its select; reset clears it immediately.
    // A write coinciding with reset is lost because the reset branch wins.
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                r_regs[g]  <= '0;
                r_valid[g] <= 1'b0;
            end else if (w_wr_sel[g]) begin
                r_regs[g]  <= IN;
                r_valid[g] <= 1'b1;
            end
        end
    end

    // Stored-content read muxes for both ports.
    always_comb begin
        w_rd1_data = r_regs[OUT1ADDRESS];
        w_rd2_data = r_regs[OUT2ADDRESS];
        w_rd1_vld  = r_valid[OUT1ADDRESS];
        w_rd2_vld  = r_valid[OUT2ADDRESS];
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write to any port reading the same register.
    // Gated by RESET so the ports still read 0 while reset is held.
    always_comb begin
        OUT1       = w_rd1_data;
        OUT2       = w_rd2_data;
        OUT1_VALID = w_rd1_vld;
        OUT2_VALID = w_rd2_vld;
        if (RESET && w_wr_en && (OUT1ADDRESS == INADDRESS)) begin
            OUT1       = IN;
            OUT1_VALID = 1'b1;
        end
        if (RESET && w_wr_en && (OUT2ADDRESS == INADDRESS)) begin
            OUT2       = IN;
            OUT2_VALID = 1'b1;
        end
    end
`else
    // Read ports show stored contents only; a same-cycle write is seen
    // after the edge.
    always_comb begin
        OUT1       = w_rd1_data;
        OUT2       = w_rd2_data;
        OUT1_VALID = w_rd1_vld;
        OUT2_VALID = w_rd2_vld;
    end
`endif

    // Expose the whole valid mask; bit i belongs to register i.
    always_comb begin
        VALID_MASK = r_valid;
    end

endmodule
